// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects MSB-first bits into DATA_W-bit words and flushes partial words on a valid gap.
// Define DESER_STATS_EN to add saturating full-word and partial-flush counters.
module deserializer #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [LEN_W-1:0]  deser_len_o,
  output logic              deser_data_val_o,
  output logic              busy_o
`ifdef DESER_STATS_EN
  ,
  output logic [15:0]       partial_cnt_o,
  output logic [15:0]       word_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1
  } state_t;

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DATA_W - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] next_sh;
  logic              full_done;
  logic              gap_done;

  // Low bits of sh are still zero, so OR-ing the incoming bit at DATA_W-1-cnt is enough.
  assign bit_mask  = {1'b1, {(DATA_W-1){1'b0}}} >> cnt;
  assign next_sh   = ser_data_i ? (sh | bit_mask) : sh;
  assign full_done = (state == COLLECT) && ser_data_val_i && (cnt == LAST_IDX);
  assign gap_done  = (state == COLLECT) && !ser_data_val_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state            <= IDLE;
      sh               <= '0;
      cnt              <= '0;
      deser_data_o     <= '0;
      deser_len_o      <= '0;
      deser_data_val_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ser_data_val_i) begin
            sh     <= {ser_data_i, {(DATA_W-1){1'b0}}};
            cnt    <= LEN_W'(1);
            state  <= COLLECT;
            busy_o <= 1'b1;
          end
        end
        COLLECT: begin
          if (full_done) begin
            deser_data_o     <= next_sh;
            deser_len_o      <= FULL_LEN;
            deser_data_val_o <= 1'b1;
            sh               <= '0;
            cnt              <= '0;
            state            <= IDLE;
            busy_o           <= 1'b0;
          end else if (ser_data_val_i) begin
            sh  <= next_sh;
            cnt <= cnt + 1'b1;
          end else begin
            deser_data_o     <= sh;
            deser_len_o      <= cnt;
            deser_data_val_o <= 1'b1;
            sh               <= '0;
            cnt              <= '0;
            state            <= IDLE;
            busy_o           <= 1'b0;
          end
        end
        default: begin
          sh     <= '0;
          cnt    <= '0;
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef DESER_STATS_EN
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      partial_cnt_o <= '0;
      word_cnt_o    <= '0;
    end else begin
      if (gap_done && (partial_cnt_o != 16'hFFFF)) begin
        partial_cnt_o <= partial_cnt_o + 16'd1;
      end
      if (full_done && (word_cnt_o != 16'hFFFF)) begin
        word_cnt_o <= word_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer: full words, back-to-back, partial flushes and async reset.
// Stats checks are compiled in only when DESER_STATS_EN is defined.
module tb_deserializer;

  logic        clk_i;
  logic        arst_n_i;
  logic        ser_data_i;
  logic        ser_data_val_i;
  logic [15:0] deser_data_o;
  logic [4:0]  deser_len_o;
  logic        deser_data_val_o;
  logic        busy_o;
`ifdef DESER_STATS_EN
  logic [15:0] partial_cnt_o;
  logic [15:0] word_cnt_o;
`endif

  int compare_cnt = 0;
  int fail_cnt    = 0;
  int cyc         = 0;

  logic [15:0] pdata_q[$];
  logic [4:0]  plen_q[$];
  int          pcyc_q[$];

  deserializer #(.DATA_W(16)) dut (
    .clk_i            (clk_i),
    .arst_n_i         (arst_n_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_len_o      (deser_len_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
`ifdef DESER_STATS_EN
    ,
    .partial_cnt_o    (partial_cnt_o),
    .word_cnt_o       (word_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Every high cycle of the strobe is logged, so a stuck pulse shows up as an extra entry.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    if (deser_data_val_o) begin
      pdata_q.push_back(deser_data_o);
      plen_q.push_back(deser_len_o);
      pcyc_q.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearPulses();
    pdata_q.delete();
    plen_q.delete();
    pcyc_q.delete();
  endtask

  task automatic applyStimulus(input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_i);
      ser_data_i     = word[15-i];
      ser_data_val_i = 1'b1;
    end
    @(negedge clk_i);
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic checkSingle(input string tag, input logic [15:0] exp_data, input logic [4:0] exp_len);
    checkOutput({tag, "_pulses"}, pdata_q.size(), 1);
    if (pdata_q.size() > 0) begin
      checkOutput({tag, "_data"}, pdata_q[0], exp_data);
      checkOutput({tag, "_len"}, plen_q[0], exp_len);
    end
  endtask

  initial begin
    int start;
    int busy_low;
    arst_n_i       = 1'b0;
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_data", deser_data_o, 16'h0000);
    checkOutput("rst_len", deser_len_o, 5'd0);
    checkOutput("rst_val", deser_data_val_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    arst_n_i = 1'b1;
    @(negedge clk_i);

    clearPulses();
    applyStimulus(16'hA5C3, 16);
    checkSingle("full", 16'hA5C3, 5'd16);
    checkOutput("full_hold_data", deser_data_o, 16'hA5C3);
    checkOutput("full_hold_val", deser_data_val_o, 1'b0);
    checkOutput("full_idle_busy", busy_o, 1'b0);

    // Reset asserted mid-cycle must clear outputs before any clock edge.
    @(posedge clk_i);
    #3;
    arst_n_i = 1'b0;
    #1;
    checkOutput("async_rst_data", deser_data_o, 16'h0000);
    checkOutput("async_rst_len", deser_len_o, 5'd0);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("async_rst_busy", busy_o, 1'b0);

    clearPulses();
    busy_low = 0;
    start = cyc;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      if (i == 0) start = cyc;
      if (i > 0 && !busy_o) busy_low++;
      ser_data_i     = (i < 16) ? 1'(16'h1234 >> (15 - i)) : 1'b1;
      ser_data_val_i = 1'b1;
    end
    @(negedge clk_i);
    ser_data_val_i = 1'b0;
    ser_data_i     = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("b2b_pulses", pdata_q.size(), 2);
    checkOutput("b2b_busy_low", busy_low, 1);
    if (pdata_q.size() == 2) begin
      checkOutput("b2b_data0", pdata_q[0], 16'h1234);
      checkOutput("b2b_cyc0", pcyc_q[0] - start + 1, 17);
      checkOutput("b2b_data1", pdata_q[1], 16'hFFFF);
      checkOutput("b2b_cyc1", pcyc_q[1] - start + 1, 33);
      checkOutput("b2b_len1", plen_q[1], 5'd16);
    end

    clearPulses();
    applyStimulus(16'hB000, 5);
    checkSingle("part5", 16'hB000, 5'd5);
    clearPulses();
    applyStimulus(16'h4C21, 16);
    checkSingle("after_part", 16'h4C21, 5'd16);
    clearPulses();
    applyStimulus(16'hFFFF, 1);
    checkSingle("part1", 16'h8000, 5'd1);
    clearPulses();
    applyStimulus(16'h7FFF, 15);
    checkSingle("part15", 16'h7FFE, 5'd15);

    // Abort a 9-bit word with reset; only the following word may produce a pulse.
    clearPulses();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      ser_data_i     = 1'b1;
      ser_data_val_i = 1'b1;
    end
    #2;
    arst_n_i = 1'b0;
    #1;
    checkOutput("abort_busy", busy_o, 1'b0);
    ser_data_val_i = 1'b0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    applyStimulus(16'h00FF, 16);
    checkSingle("abort_next", 16'h00FF, 5'd16);

`ifdef DESER_STATS_EN
    @(negedge clk_i);
    arst_n_i = 1'b0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    checkOutput("stats_rst_word", word_cnt_o, 16'd0);
    applyStimulus(16'h1111, 16);
    applyStimulus(16'hF000, 3);
    applyStimulus(16'h2222, 16);
    applyStimulus(16'hC000, 7);
    applyStimulus(16'h3333, 16);
    checkOutput("stats_word", word_cnt_o, 16'd3);
    checkOutput("stats_partial", partial_cnt_o, 16'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule
